// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Instruction register and Moore control FSM sequencing the 16-bit datapath.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WRITE_IMM,
        S_WRITE_REG,
        S_ILLEGAL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;

    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_alu;
    logic        is_cmp;
    logic        is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // The IR only accepts a new word while idle, so DECODE and later stages always see a stable instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if (load && (state == S_WAIT)) begin
                ir <= in;
            end
        end
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        err        = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        ALUop      = 2'b00;
        shift      = 2'b00;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // MOV reg and MVN have no A operand, so they skip straight to fetching Rm.
                if (is_mov_imm) begin
                    state_next = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_next = S_GET_B;
                end else if (is_alu) begin
                    state_next = S_GET_A;
                end else begin
                    state_next = S_ILLEGAL;
                end
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                shift = sh;
                loadc = 1'b1;
                // MOV reg is computed as 0 + shifted Rm.
                ALUop = is_alu ? op : 2'b00;
                asel  = is_mov_reg;
                loads = is_cmp;
                state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum   = rd;
                vsel       = 1'b1;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = 1'b0;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_ILLEGAL: begin
                err        = 1'b1;
                state_next = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - Directed self-checking bench for cpu_controller.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8;

    int checks;
    int failures;

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, shift}
    logic [19:0] ctl_obs;
    assign ctl_obs = {w, err, readnum, writenum, write, vsel, loada, loadb,
                      loadc, loads, asel, bsel, ALUop, shift};

    function automatic logic [19:0] ctl(
        input logic       w_e,
        input logic       err_e,
        input logic [2:0] rn_e,
        input logic [2:0] wn_e,
        input logic       wr_e,
        input logic       vs_e,
        input logic       la_e,
        input logic       lb_e,
        input logic       lc_e,
        input logic       ls_e,
        input logic       asl_e,
        input logic [1:0] alu_e,
        input logic [1:0] sh_e
    );
        return {w_e, err_e, rn_e, wn_e, wr_e, vs_e, la_e, lb_e, lc_e, ls_e, asl_e, 1'b0, alu_e, sh_e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] word);
        load = 1'b1;
        in   = word;
        tick();
        load = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        s        = 1'b0;
        load     = 1'b0;
        in       = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ctl", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        chk("reset_imm", {16'd0, sximm8}, 32'h0000);

        // MOV R0,#7 with load and s on the same edge
        load = 1'b1; in = 16'hD007; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        chk("movi_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("movi_write", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,1,0,0,0,0,0,0,2'b00,2'b00)});
        chk("movi_imm", {16'd0, sximm8}, 32'h0007);
        tick();
        chk("movi_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // MOV R1,#-2
        load_ir(16'hD1FE);
        chk("movi2_idle", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        s = 1'b1; tick(); s = 1'b0;
        tick();
        chk("movi2_write", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00)});
        chk("movi2_imm", {16'd0, sximm8}, 32'hFFFE);
        tick();
        chk("movi2_wait", {27'd0, w, write}, 32'h2);

        // ADD R2,R1,R0,LSL#1
        load_ir(16'hA148);
        s = 1'b1; tick(); s = 1'b0;
        chk("add_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("add_geta", {12'd0, ctl_obs}, {12'd0, ctl(0,0,1,0,0,0,1,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("add_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        tick();
        chk("add_compute", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b01)});
        tick();
        chk("add_writereg", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,2,1,1,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("add_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // CMP R0,R1
        load_ir(16'hA801);
        s = 1'b1; tick(); s = 1'b0;
        chk("cmp_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("cmp_geta", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,1,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("cmp_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,1,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        tick();
        chk("cmp_compute", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,1,1,0,2'b01,2'b00)});
        tick();
        chk("cmp_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // MOV R7,R2 with a load attempt during COMPUTE
        load_ir(16'hC0E2);
        s = 1'b1; tick(); s = 1'b0;
        tick();
        chk("movr_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,2,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        tick();
        chk("movr_compute", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,1,0,1,2'b00,2'b00)});
        load = 1'b1; in = 16'hE000;
        tick();
        load = 1'b0;
        chk("movr_writereg", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,7,1,1,0,0,0,0,0,2'b00,2'b00)});
        chk("movr_ir_locked", {16'd0, sximm8}, 32'hFFE2);
        tick();
        chk("movr_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // MVN R5,R1 with s held high: back-to-back re-execution
        load_ir(16'hB8A1);
        s = 1'b1; tick();
        chk("mvn_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("mvn_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,1,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        tick();
        chk("mvn_compute", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,1,0,0,2'b11,2'b00)});
        tick();
        chk("mvn_writereg", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,5,1,1,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("mvn_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("b2b_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        s = 1'b0;
        tick();
        chk("b2b_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,1,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        tick(); tick(); tick();
        chk("b2b_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // Illegal opcode 111
        load_ir(16'hE000);
        s = 1'b1; tick(); s = 1'b0;
        chk("ill_decode", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("ill_err", {12'd0, ctl_obs}, {12'd0, ctl(0,1,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        tick();
        chk("ill_wait", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        // Asynchronous reset in the middle of an ADD's GET_B
        load_ir(16'hA148);
        s = 1'b1; tick(); s = 1'b0;
        tick(); tick();
        chk("rst_pre_getb", {12'd0, ctl_obs}, {12'd0, ctl(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00)});
        #2 reset = 1'b1;
        #1;
        chk("rst_async_ctl", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});
        chk("rst_async_ir", {16'd0, sximm8}, 32'h0000);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_release", {12'd0, ctl_obs}, {12'd0, ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
